// File: rtl/half_adder_pkg.sv
// Shared constants and result type for the registered half-adder slice.
package half_adder_pkg;
  localparam int HA_DEFAULT_WIDTH = 1;
  localparam int HA_DEFAULT_CNT_W = 16;

  typedef struct packed {
    logic sum;
    logic carry;
  } ha_result_t;
endpackage

// File: rtl/half_adder_reg_ha_cell.sv
// Purely combinational 1-bit half adder.
module ha_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// File: rtl/half_adder_reg.sv
// Registered lane-parallel half adder with a valid bit travelling beside the data.
// Optional saturating carry-event counter when HALF_ADDER_STATS_EN is defined.
module half_adder_reg
  import half_adder_pkg::*;
#(
  parameter int WIDTH = HA_DEFAULT_WIDTH,
  parameter int CNT_W = HA_DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Sum,
  output logic [WIDTH-1:0] Carry,
`ifdef HALF_ADDER_STATS_EN
  output logic [CNT_W-1:0] carry_count,
`endif
  output logic             out_valid
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_cfg
    $error("half_adder_reg: WIDTH and CNT_W must be >= 1");
  end

  ha_result_t [WIDTH-1:0] res;
  logic [WIDTH-1:0] sum_d, sum_q, carry_d, carry_q;
  logic             valid_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    ha_cell u_cell (.a(A[i]), .b(B[i]), .s(res[i].sum), .c(res[i].carry));
  end

  // Idle cycles hold the last result so X on A/B cannot leak through.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    if (in_valid) begin
      for (int i = 0; i < WIDTH; i++) begin
        sum_d[i]   = res[i].sum;
        carry_d[i] = res[i].carry;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= '0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= in_valid;
    end
  end

  assign Sum       = sum_q;
  assign Carry     = carry_q;
  assign out_valid = valid_q;

`ifdef HALF_ADDER_STATS_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // One event per cycle with any lane carrying; sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (in_valid && (|(A & B)) && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign carry_count = cnt_q;
`endif

endmodule

// File: tb/tb_half_adder_reg.sv
// Bench for half_adder_reg: a WIDTH=1 (CNT_W=2) and a WIDTH=4 instance, directed
// steps followed by random traffic, checked against an arithmetic lane model.
module tb_half_adder_reg;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [0:0] a1 = '0, b1 = '0;
  logic       v1 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       v4 = 1'b0;
  logic [0:0] s1, c1;
  logic [3:0] s4, c4;
  logic       ov1, ov4;
`ifdef HALF_ADDER_STATS_EN
  logic [1:0]  cnt1;
  logic [15:0] cnt4;
`endif

  int total = 0;
  int bad   = 0;

  // reference state
  logic [0:0] m1_s, m1_c;
  logic [3:0] m4_s, m4_c;
  logic       m1_v, m4_v;
  int         m1_cnt, m4_cnt;

  always #10 clk = ~clk;

  half_adder_reg #(.WIDTH(1), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .in_valid(v1),
    .Sum(s1), .Carry(c1),
`ifdef HALF_ADDER_STATS_EN
    .carry_count(cnt1),
`endif
    .out_valid(ov1));

  half_adder_reg #(.WIDTH(4), .CNT_W(16)) u4 (
    .clk(clk), .rst(rst), .A(a4), .B(b4), .in_valid(v4),
    .Sum(s4), .Carry(c4),
`ifdef HALF_ADDER_STATS_EN
    .carry_count(cnt4),
`endif
    .out_valid(ov4));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m1_s = '0; m1_c = '0; m1_v = 1'b0; m1_cnt = 0;
    m4_s = '0; m4_c = '0; m4_v = 1'b0; m4_cnt = 0;
  endtask

  // Lane result as plain addition: low bit is the sum, high bit the carry.
  task automatic model_edge(input logic [3:0] a, input logic [3:0] b, input logic v,
                            input int w, input int cmax,
                            inout logic [3:0] ms, inout logic [3:0] mc,
                            inout logic mv, inout int mcnt);
    bit any_c = 0;
    mv = v;
    if (v) begin
      for (int i = 0; i < w; i++) begin
        int t = int'(a[i]) + int'(b[i]);
        ms[i] = t % 2;
        mc[i] = t / 2;
        if (t == 2) any_c = 1;
      end
      if (any_c && mcnt < cmax) mcnt++;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".sum1"},  16'(s1),  16'(m1_s));
    chk({tag, ".car1"},  16'(c1),  16'(m1_c));
    chk({tag, ".vld1"},  16'(ov1), 16'(m1_v));
    chk({tag, ".sum4"},  16'(s4),  16'(m4_s));
    chk({tag, ".car4"},  16'(c4),  16'(m4_c));
    chk({tag, ".vld4"},  16'(ov4), 16'(m4_v));
`ifdef HALF_ADDER_STATS_EN
    chk({tag, ".cnt1"},  16'(cnt1), 16'(m1_cnt));
    chk({tag, ".cnt4"},  16'(cnt4), 16'(m4_cnt));
`endif
  endtask

  // Drive both instances for one cycle, advance the model at the edge, check at +1.
  task automatic step(input string tag, input logic [0:0] ia1, input logic [0:0] ib1, input logic iv1,
                      input logic [3:0] ia4, input logic [3:0] ib4, input logic iv4);
    logic [3:0] t_s, t_c;
    a1 = ia1; b1 = ib1; v1 = iv1;
    a4 = ia4; b4 = ib4; v4 = iv4;
    @(posedge clk);
    t_s = 4'(m1_s); t_c = 4'(m1_c);
    model_edge(4'(ia1), 4'(ib1), iv1, 1, 3, t_s, t_c, m1_v, m1_cnt);
    m1_s = t_s[0:0]; m1_c = t_c[0:0];
    model_edge(ia4, ib4, iv4, 4, 65535, m4_s, m4_c, m4_v, m4_cnt);
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    a1 = 'x; b1 = 'x; a4 = 'x; b4 = 'x;
    #3;
    check_all("reset");
    @(posedge clk); #1;
    check_all("reset_edge");
    rst = 1'b0;

    // truth table on one lane, with literal expectations alongside the model
    step("tt00", 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
    chk("tt00.lit", {s1, c1}, 16'b00);
    step("tt01", 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0);
    chk("tt01.lit", {s1, c1}, 16'b10);
    step("tt10", 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
    chk("tt10.lit", {s1, c1}, 16'b10);
    step("tt11", 1'b1, 1'b1, 1'b1, 4'hC, 4'hA, 1'b1);
    chk("tt11.lit", {s1, c1}, 16'b01);
    chk("w4.sum.lit", 16'(s4), 16'h6);
    chk("w4.car.lit", 16'(c4), 16'h8);

    // hold on idle, with X on the idle inputs
    step("idle", 1'b0, 1'b1, 1'b0, 4'hx, 4'hx, 1'b0);
    chk("idle.lit", {s1, c1, ov1}, 16'b010);

    // async reset between edges while Sum=1; the pending valid result is dropped
    step("pre_rst", 1'b1, 1'b0, 1'b1, 4'hF, 4'h0, 1'b1);
    #4;
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1; a4 = 4'hF; b4 = 4'hF; v4 = 1'b1;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk); #1;
    check_all("rst_hold");
    rst = 1'b0;
    step("post_rst", 1'b1, 1'b0, 1'b1, 4'h5, 4'h3, 1'b1);
    chk("post_rst.lit", {s1, c1, ov1}, 16'b101);

    // carry counter saturation on the 2-bit instance: 1,2,3,3,3
    for (int i = 0; i < 5; i++) step($sformatf("sat%0d", i), 1'b1, 1'b1, 1'b1, 4'h1, 4'h1, 1'b1);
`ifdef HALF_ADDER_STATS_EN
    chk("sat.cnt1.lit", 16'(cnt1), 16'd3);
`endif

    // random back-to-back traffic, idle cycles carry X on the addends
    for (int n = 0; n < 300; n++) begin
      logic       rv1, rv4;
      logic [0:0] ra1, rb1;
      logic [3:0] ra4, rb4;
      rv1 = ($urandom_range(0, 3) != 0);
      rv4 = ($urandom_range(0, 3) != 0);
      ra1 = 1'($urandom); rb1 = 1'($urandom);
      ra4 = 4'($urandom); rb4 = 4'($urandom);
      if (!rv1 && n[0]) begin ra1 = 'x; rb1 = 'x; end
      if (!rv4 && n[1]) begin ra4 = 'x; rb4 = 'x; end
      step($sformatf("rnd%0d", n), ra1, rb1, rv1, ra4, rb4, rv4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
